// File: rtl/scmips_pkg.sv
// Shared register-file constants and the pending-write entry type.
package scmips_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// Circular FIFO of pending register writes; the storage and read pointer are
// exposed so the top level can search the pending entries.
module wb_entry_fifo
  import scmips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output wb_entry_t [DEPTH-1:0]  entries,
  output logic [PTR_W-1:0]       rd_ptr,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign entries = mem_q;
  assign rd_ptr  = rd_ptr_q;
  assign count   = count_q;

endmodule

// File: rtl/reg_writeback_buffer.sv
// Register-file write buffer: filters $R0 writes, drains one entry per cycle.
// Optional bypass lookup enabled by defining REG_WB_BYPASS_EN.
module reg_writeback_buffer
  import scmips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rf_ready,
  output logic [ADDR_W-1:0] reg_write,
  output logic              reg_write_signal,
  output logic [DATA_W-1:0] in_data,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data
);

  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full, empty, push;

  // $R0 writes complete the handshake but are never queued.
  assign push             = wb_valid && !full && (wb_addr != REG_ZERO);
  assign wb_ready         = !full;
  assign reg_write_signal = !empty && rf_ready;
  assign reg_write        = empty ? '0 : head.addr;
  assign in_data          = empty ? '0 : head.data;

  wb_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry ('{addr: wb_addr, data: wb_data}),
    .pop        (reg_write_signal),
    .head       (head),
    .entries    (entries),
    .rd_ptr     (rd_ptr),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

`ifdef REG_WB_BYPASS_EN
  // Walk oldest to youngest so the last match is the youngest pending write.
  always_comb begin
    logic [PTR_W-1:0] idx;
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (lk_addr != REG_ZERO) && (entries[idx].addr == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = entries[idx].data;
      end
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{lk_addr, entries, rd_ptr};
  assign lk_hit        = 1'b0;
  assign lk_data       = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Self-checking bench for reg_writeback_buffer: queue-based model plus directed tests.
module tb_reg_writeback_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wb_valid = 1'b0;
  logic       wb_ready;
  logic [2:0] wb_addr = '0;
  logic [7:0] wb_data = '0;
  logic       rf_ready = 1'b0;
  logic [2:0] reg_write;
  logic       reg_write_signal;
  logic [7:0] in_data;
  logic [2:0] count;
  logic [2:0] lk_addr = '0;
  logic       lk_hit;
  logic [7:0] lk_data;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  ent_t       q[$];
  logic [7:0] rf_dut[8];
  logic [7:0] seen[$];

  always #5 clk = ~clk;

  reg_writeback_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .rf_ready         (rf_ready),
    .reg_write        (reg_write),
    .reg_write_signal (reg_write_signal),
    .in_data          (in_data),
    .count            (count),
    .lk_addr          (lk_addr),
    .lk_hit           (lk_hit),
    .lk_data          (lk_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending writes as a plain queue, updated from the inputs at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit pop, acc;
      pop = (q.size() != 0) && rf_ready;
      acc = wb_valid && (q.size() != DEPTH);
      if (pop) void'(q.pop_front());
      if (acc && wb_addr != 3'd0) q.push_back('{addr: wb_addr, data: wb_data});
    end
  end

  // Register file as seen through the DUT's write port.
  always @(negedge clk) begin
    if (rst_n && reg_write_signal === 1'b1) begin
      rf_dut[reg_write] = in_data;
      seen.push_back(in_data);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic       e_hit;
      logic [7:0] e_lk;
      e_hit = 1'b0;
      e_lk  = '0;
`ifdef REG_WB_BYPASS_EN
      foreach (q[i]) begin
        if (lk_addr != 3'd0 && q[i].addr == lk_addr) begin
          e_hit = 1'b1;
          e_lk  = q[i].data;
        end
      end
`endif
      chk("count", 32'(count), 32'(q.size()));
      chk("wb_ready", 32'(wb_ready), 32'(q.size() != DEPTH));
      chk("strobe", 32'(reg_write_signal), 32'((q.size() != 0) && rf_ready));
      chk("reg_write", 32'(reg_write), (q.size() != 0) ? 32'(q[0].addr) : 32'd0);
      chk("in_data", 32'(in_data), (q.size() != 0) ? 32'(q[0].data) : 32'd0);
      chk("lk_hit", 32'(lk_hit), 32'(e_hit));
      chk("lk_data", 32'(lk_data), 32'(e_lk));
    end
  end

  task automatic drive(input logic v, input logic [2:0] a, input logic [7:0] d, input logic r);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
    rf_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_seen(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, 32'(seen.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < seen.size()) chk(name, 32'(seen[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [7:0] exp3[$];
    logic [7:0] exp6[$];
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ready", 32'(wb_ready), 32'd1);

    // 1: reset while draining
    drive(1, 3'd1, 8'h01, 0);
    drive(1, 3'd2, 8'h02, 0);
    drive(1, 3'd3, 8'h03, 0);
    drive(0, 3'd0, 8'h00, 1);
    chk("t1_mid_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_strobe", 32'(reg_write_signal), 32'd0);
    chk("t1_ready", 32'(wb_ready), 32'd1);
    chk("t1_in_data", 32'(in_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 2: single write
    drive(1, 3'd5, 8'hA5, 1);
    chk("t2_strobe", 32'(reg_write_signal), 32'd1);
    chk("t2_reg_write", 32'(reg_write), 32'd5);
    chk("t2_in_data", 32'(in_data), 32'hA5);
    drive(0, 3'd0, 8'h00, 1);
    chk("t2_rf5", 32'(rf_dut[5]), 32'hA5);
    chk("t2_count", 32'(count), 32'd0);

    // 3: backpressure
    seen.delete();
    lk_addr = 3'd2;
    for (int i = 1; i <= 5; i++) drive(1, 3'(i), 8'(8'h10 + i), 0);
    chk("t3_full_count", 32'(count), 32'd4);
    chk("t3_not_ready", 32'(wb_ready), 32'd0);
    drive(1, 3'd5, 8'h15, 1);
    chk("t3_after_pop", 32'(count), 32'd3);
    drive(1, 3'd5, 8'h15, 1);
    chk("t3_fifth_in", 32'(count), 32'd3);
    repeat (5) drive(0, 3'd0, 8'h00, 1);
    exp3 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    chk_seen("t3_order", exp3);

    // 4: R0 filter
    chk("t4_ready", 32'(wb_ready), 32'd1);
    drive(1, 3'd0, 8'hFF, 1);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_strobe", 32'(reg_write_signal), 32'd0);

    // 5: same register twice
    lk_addr = 3'd3;
    drive(1, 3'd3, 8'd11, 0);
    drive(1, 3'd3, 8'd22, 0);
    drive(0, 3'd0, 8'h00, 0);
`ifdef REG_WB_BYPASS_EN
    chk("t5_lk_hit", 32'(lk_hit), 32'd1);
    chk("t5_lk_data", 32'(lk_data), 32'd22);
`else
    chk("t5_lk_hit", 32'(lk_hit), 32'd0);
    chk("t5_lk_data", 32'(lk_data), 32'd0);
`endif
    lk_addr = 3'd0;
    #1 chk("t5_lk_r0", 32'(lk_hit), 32'd0);
    repeat (3) drive(0, 3'd0, 8'h00, 1);
    chk("t5_rf3", 32'(rf_dut[3]), 32'd22);

    // 6: concurrent push/pop at count=2
    seen.delete();
    lk_addr = 3'd4;
    drive(1, 3'd1, 8'h61, 0);
    drive(1, 3'd2, 8'h62, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 3'((i % 7) + 1), 8'(8'h70 + i), 1);
      chk("t6_count", 32'(count), 32'd2);
    end
    repeat (3) drive(0, 3'd0, 8'h00, 1);
    exp6 = '{8'h61, 8'h62, 8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    chk_seen("t6_order", exp6);
    chk("t6_rf4", 32'(rf_dut[4]), 32'h73);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
